// File: rtl/ep6_merge_pkg.sv
// ep6_merge_pkg
//   Shared definitions for the EP6 stream merger:
//   - arbitration mode encodings (ARB_FIXED, ARB_RR)
//   - drop counter width
//   - rr_first(): round-robin "first set bit at or after ptr" search, which
//     also serves fixed priority when called with ptr = 0.
package ep6_merge_pkg;

  localparam int ARB_FIXED  = 0;
  localparam int ARB_RR     = 1;
  localparam int DROP_CNT_W = 16;
  localparam int MAX_NCH    = 8;

  // Returns {found, index[2:0]} of the first set bit of req[nch-1:0]
  // searching upward from ptr and wrapping at nch.
  function automatic logic [3:0] rr_first(input logic [MAX_NCH-1:0] req,
                                          input logic [2:0]         ptr,
                                          input int                 nch);
    logic [3:0] res;
    int         j;
    res = '0;
    // Scan from the far end back toward ptr so the nearest hit overwrites.
    for (int i = MAX_NCH - 1; i >= 0; i--) begin
      if (i < nch) begin
        j = int'(ptr) + i;
        if (j >= nch) j = j - nch;
        if (req[j[2:0]]) res = {1'b1, j[2:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ep6_stream_merge_fifo.sv
// ep6_chan_fifo
//   Synchronous show-ahead FIFO for one merger channel. dout always shows
//   the head word while !empty, so a pop consumes the word already on dout.
//   Ports:
//     clk_100  system clock
//     rst_n    asynchronous active-low reset (pointers/count only)
//     din      write data
//     wr_en    push request (ignored when full unless a pop happens too)
//     rd_en    pop request (ignored when empty)
//     dout     head word
//     empty    no words stored
//     full     DEPTH words stored
//     count    words stored, 0..DEPTH
module ep6_chan_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_100,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_wr;
  logic          do_rd;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign count = count_reg;
  assign dout  = mem[rd_ptr_reg];

  assign do_rd = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_wr = wr_en && (!full || do_rd);

  // Storage carries no reset; only the pointers define valid contents.
  always_ff @(posedge clk_100) begin
    if (do_wr) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ep6_stream_merge.sv
// ep6_stream_merge
//   Buffers NCH word streams in per-channel FIFOs, gates each channel with a
//   hold-off timer and serialises the eligible channels onto one registered
//   valid/ready stream tagged with the source channel.
//   Ports:
//     clk_100    system clock
//     rst_n      asynchronous active-low reset
//     in_data    channel c at [c*DW +: DW]
//     in_valid   per-channel write strobe (no back-pressure)
//     out_data   merged word
//     out_chan   source channel of out_data
//     out_valid  out_data/out_chan valid
//     out_ready  downstream accepts the word
//     ovf        sticky per-channel overflow flags
//     drop_cnt   saturating count of dropped writes, all channels
module ep6_stream_merge
  import ep6_merge_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int DW       = 32,
  parameter int DEPTH    = 16,
  parameter int HOLDOFF  = 400,
  parameter int ARB_MODE = ARB_FIXED,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk_100,
  input  logic                  rst_n,
  input  logic [NCH*DW-1:0]     in_data,
  input  logic [NCH-1:0]        in_valid,
  output logic [DW-1:0]         out_data,
  output logic [CW-1:0]         out_chan,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH-1:0]        ovf,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [DW-1:0]         fifo_dout [NCH];
  logic [AW:0]           fifo_count [NCH];
  logic [NCH-1:0]        fifo_empty;
  logic [NCH-1:0]        fifo_full;
  logic [NCH-1:0]        eligible;
  logic [NCH-1:0]        rd_en;
  logic [NCH-1:0]        wr_ok;
  logic [NCH-1:0]        drop;

  logic [3:0]            pick;
  logic                  grant_found;
  logic [CW-1:0]         grant_idx;
  logic [DW-1:0]         head_data;
  logic                  load;

  logic [CW-1:0]         rr_ptr_reg;
  logic [DW-1:0]         out_data_reg;
  logic [CW-1:0]         out_chan_reg;
  logic                  out_valid_reg;
  logic [NCH-1:0]        ovf_reg;
  logic [DROP_CNT_W-1:0] drop_cnt_reg;
  logic [DROP_CNT_W-1:0] drop_cnt_next;
  logic [3:0]            drop_sum;
  logic [DROP_CNT_W:0]   drop_total;

  // Per-channel FIFO, write qualification and hold-off timer
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic [HW-1:0] hold_cnt_reg;

    ep6_chan_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_100 (clk_100),
      .rst_n   (rst_n),
      .din     (in_data[gi*DW +: DW]),
      .wr_en   (wr_ok[gi]),
      .rd_en   (rd_en[gi]),
      .dout    (fifo_dout[gi]),
      .empty   (fifo_empty[gi]),
      .full    (fifo_full[gi]),
      .count   (fifo_count[gi])
    );

    assign rd_en[gi] = load && (grant_idx == CW'(gi));
    assign wr_ok[gi] = in_valid[gi] && ((fifo_count[gi] < (AW+1)'(DEPTH)) || rd_en[gi]);
    assign drop[gi]  = in_valid[gi] && fifo_full[gi] && !rd_en[gi];

    // Counts cycles of continuous occupancy; an empty FIFO restarts it.
    always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
        hold_cnt_reg <= '0;
      end else if (fifo_empty[gi]) begin
        hold_cnt_reg <= '0;
      end else if (hold_cnt_reg != HW'(HOLDOFF)) begin
        hold_cnt_reg <= hold_cnt_reg + 1'b1;
      end
    end

    assign eligible[gi] = !fifo_empty[gi] && (hold_cnt_reg == HW'(HOLDOFF));
  end

  // Arbiter: fixed priority is a round-robin search anchored at channel 0.
  always_comb begin
    if (ARB_MODE == ARB_RR) begin
      pick = rr_first(MAX_NCH'(eligible), 3'(rr_ptr_reg), NCH);
    end else begin
      pick = rr_first(MAX_NCH'(eligible), 3'd0, NCH);
    end
    grant_found = pick[3];
    grant_idx   = '0;
    head_data   = '0;
    for (int c = 0; c < NCH; c++) begin
      if (pick[2:0] == 3'(c)) begin
        grant_idx = CW'(c);
        head_data = fifo_dout[c];
      end
    end
  end

  // The output register can take a word when empty or being emptied now.
  assign load = (!out_valid_reg || out_ready) && grant_found;

  // Drop accounting: add the number of channels dropping this cycle.
  always_comb begin
    drop_sum = '0;
    for (int c = 0; c < NCH; c++) begin
      drop_sum = drop_sum + 4'(drop[c]);
    end
    drop_total    = {1'b0, drop_cnt_reg} + (DROP_CNT_W+1)'(drop_sum);
    drop_cnt_next = drop_total[DROP_CNT_W] ? '1 : drop_total[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      out_valid_reg <= 1'b0;
      ovf_reg       <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      ovf_reg      <= ovf_reg | drop;
      drop_cnt_reg <= drop_cnt_next;
      if (load) begin
        out_data_reg  <= head_data;
        out_chan_reg  <= grant_idx;
        out_valid_reg <= 1'b1;
        if (ARB_MODE == ARB_RR) begin
          rr_ptr_reg <= (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
        end
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;
  assign out_valid = out_valid_reg;
  assign ovf       = ovf_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule
